// File: rtl/set_mode_controller.sv
// Front-panel sequencer for the clock/calendar datapath: turns mode/set/up/down buttons into
// edit-state selection, single-cycle up/down pulses with hold-to-repeat, timeout and blink.
module set_mode_controller #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_CYCLES   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       mode_time,
  output logic       manual_set,
  output logic [2:0] select_item,
  output logic       up,
  output logic       down,
  output logic       blink
);

  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

  // Encoding equals the select_item code so the state register drives the output directly.
  typedef enum logic [2:0] {
    StRun  = 3'b000,
    StSec  = 3'b001,
    StMin  = 3'b010,
    StHour = 3'b011,
    StDay  = 3'b100,
    StMon  = 3'b101,
    StYear = 3'b110
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               manual_q, manual_d;
  logic               up_q, up_d;
  logic               down_q, down_d;
  logic               blink_q, blink_d;
  logic               prev_mode_q, prev_set_q, prev_up_q, prev_down_q, both_q;
  logic               rpt_active_q, rpt_active_d;
  logic               rpt_phase_q, rpt_phase_d;
  logic [RptW-1:0]    rpt_cnt_q, rpt_cnt_d, rpt_target;
  logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;

  logic mode_press, set_press, up_press, down_press, both, any_btn, in_set, pulse;

  assign mode_press = btn_mode & ~prev_mode_q;
  assign set_press  = btn_set & ~prev_set_q;
  assign both       = btn_up & btn_down;
  // A button left alone after a two-button overlap counts as a fresh press.
  assign up_press   = btn_up & ~btn_down & (~prev_up_q | both_q);
  assign down_press = btn_down & ~btn_up & (~prev_down_q | both_q);
  assign any_btn    = btn_mode | btn_set | btn_up | btn_down;
  assign in_set     = (state_q != StRun);
  assign rpt_target = rpt_phase_q ? RptW'(REPEAT_CYCLES) : RptW'(HOLD_CYCLES);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    up_d         = 1'b0;
    down_d       = 1'b0;
    pulse        = 1'b0;
    rpt_active_d = rpt_active_q;
    rpt_phase_d  = rpt_phase_q;
    rpt_cnt_d    = rpt_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;

    if (mode_press || set_press || !in_set || both || !(btn_up || btn_down)) begin
      rpt_active_d = 1'b0;
      rpt_phase_d  = 1'b0;
      rpt_cnt_d    = '0;
    end

    if (mode_press) begin
      if (in_set) state_d = StRun;
      else        mode_d  = ~mode_q;
    end else if (set_press) begin
      case (state_q)
        StRun:   state_d = mode_q ? StDay : StHour;
        StHour:  state_d = StMin;
        StMin:   state_d = StSec;
        StDay:   state_d = StMon;
        StMon:   state_d = StYear;
        default: state_d = StRun;
      endcase
    end else if (in_set && !both && (btn_up || btn_down)) begin
      if (up_press || down_press) begin
        pulse        = 1'b1;
        up_d         = up_press;
        down_d       = down_press;
        rpt_active_d = 1'b1;
        rpt_phase_d  = 1'b0;
        rpt_cnt_d    = '0;
      end else if (rpt_active_q) begin
        if (rpt_cnt_q < rpt_target) rpt_cnt_d = rpt_cnt_q + 1'b1;
        if (rpt_cnt_d == rpt_target) begin
          pulse       = 1'b1;
          up_d        = btn_up;
          down_d      = btn_down;
          rpt_phase_d = 1'b1;
          rpt_cnt_d   = '0;
        end
      end
    end

    if (!in_set || any_btn) begin
      idle_cnt_d = '0;
    end else begin
      if (idle_cnt_q < IdleW'(TIMEOUT_CYCLES)) idle_cnt_d = idle_cnt_q + 1'b1;
      if (idle_cnt_d == IdleW'(TIMEOUT_CYCLES)) begin
        state_d    = StRun;
        idle_cnt_d = '0;
      end
    end

    manual_d = (state_d != StRun);

    if (state_d == StRun) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if ((state_d != state_q) || pulse) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (blink_cnt_d == BlinkW'(BLINK_CYCLES)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      mode_q       <= 1'b0;
      manual_q     <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      blink_q      <= 1'b0;
      prev_mode_q  <= 1'b1;
      prev_set_q   <= 1'b1;
      prev_up_q    <= 1'b1;
      prev_down_q  <= 1'b1;
      both_q       <= 1'b0;
      rpt_active_q <= 1'b0;
      rpt_phase_q  <= 1'b0;
      rpt_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      manual_q     <= manual_d;
      up_q         <= up_d;
      down_q       <= down_d;
      blink_q      <= blink_d;
      prev_mode_q  <= btn_mode;
      prev_set_q   <= btn_set;
      prev_up_q    <= btn_up;
      prev_down_q  <= btn_down;
      both_q       <= both;
      rpt_active_q <= rpt_active_d;
      rpt_phase_q  <= rpt_phase_d;
      rpt_cnt_q    <= rpt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign mode_time   = mode_q;
  assign manual_set  = manual_q;
  assign select_item = state_q;
  assign up          = up_q;
  assign down        = down_q;
  assign blink       = blink_q;

endmodule
